// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment display path: glyph patterns
// (active-low, bit order g..a), decimal-point position and capture FSM states.
package ssd_pkg;

  localparam int DP_BIT = 7;

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b0000011;
  localparam logic [6:0] GLYPH_C     = 7'b0100111;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED
  } ssdState_e;

endpackage

// File: rtl/ssd_glyph_decode.sv
// Combinational segment-pattern to hex decoder. A pattern is either one of
// the 16 hex glyphs (legal), the all-dark blank, or illegal (neither flag).
module ssd_glyph_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic       blank,
  output logic [3:0] nibble
);

  // Table lookup; anything outside the glyph set clears legal
  always_comb begin
    legal  = 1'b1;
    blank  = 1'b0;
    nibble = 4'h0;
    case (seg)
      GLYPH_0:     nibble = 4'h0;
      GLYPH_1:     nibble = 4'h1;
      GLYPH_2:     nibble = 4'h2;
      GLYPH_3:     nibble = 4'h3;
      GLYPH_4:     nibble = 4'h4;
      GLYPH_5:     nibble = 4'h5;
      GLYPH_6:     nibble = 4'h6;
      GLYPH_7:     nibble = 4'h7;
      GLYPH_8:     nibble = 4'h8;
      GLYPH_9:     nibble = 4'h9;
      GLYPH_A:     nibble = 4'hA;
      GLYPH_B:     nibble = 4'hB;
      GLYPH_C:     nibble = 4'hC;
      GLYPH_D:     nibble = 4'hD;
      GLYPH_E:     nibble = 4'hE;
      GLYPH_F:     nibble = 4'hF;
      GLYPH_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:     legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_capture.sv
// Seven-segment bus capture: samples a multiplexed active-low display bus,
// waits for a digit pattern to be stable, decodes it into {dp, nibble},
// keeps a shadow of every digit and reports changes through a valid/ready port.
module ssd_capture
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              SSD,
  input  logic [NUM_DIGITS-1:0]   Anode,
  output logic [5*NUM_DIGITS-1:0] DigitsOut,
  output logic [NUM_DIGITS-1:0]   DigitValid,
  output logic                    EvValid,
  input  logic                    EvReady,
  output logic [2:0]              EvIdx,
  output logic [4:0]              EvData,
  output logic                    ErrGlyph,
  output logic                    ErrOverflow,
  input  logic                    ErrClr
);

  localparam int SW = NUM_DIGITS + 8;
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [SW-1:0]         sample_p0;
  logic [SW-1:0]         sample_p1;
  logic [NUM_DIGITS-1:0] anodeLit;
  logic [7:0]            segP0;
  logic                  anodeOk;
  logic                  same;
  logic [2:0]            digitIdx;
  logic                  legal;
  logic                  blank;
  logic [3:0]            nibble;
  logic [4:0]            newVal;
  logic [4:0]            oldVal;
  logic                  oldValid;
  logic                  captureNow;
  logic                  raiseEv;
  logic                  glyphBad;
  logic                  evBlocked;
  ssdState_e             state;
  logic [CW-1:0]         cnt;

  // ---- stage p0: registered bus; stage p1: previous sample for comparison
  // Input pipeline is pure data and carries no reset
  always_ff @(posedge clk) begin
    sample_p0 <= {Anode, SSD};
    sample_p1 <= sample_p0;
  end

  assign anodeLit = ~sample_p0[SW-1:8];
  assign segP0    = sample_p0[7:0];
  assign same     = (sample_p0 == sample_p1);
  // Exactly one digit lit; width of Anode already excludes indices >= NUM_DIGITS
  assign anodeOk  = (anodeLit != '0) &&
                    ((anodeLit & (anodeLit - NUM_DIGITS'(1))) == '0);

  // Index of the lit digit (only meaningful when anodeOk)
  always_comb begin
    digitIdx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (anodeLit[i]) digitIdx = 3'(i);
    end
  end

  ssd_glyph_decode uGlyph (
    .seg    (segP0[6:0]),
    .legal  (legal),
    .blank  (blank),
    .nibble (nibble)
  );

  assign newVal = {~segP0[DP_BIT], nibble};

  // Current shadow contents of the digit being captured
  always_comb begin
    oldVal   = '0;
    oldValid = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i == int'(digitIdx)) begin
        oldVal   = DigitsOut[5*i +: 5];
        oldValid = DigitValid[i];
      end
    end
  end

  // The edge that moves TRACK -> LOCKED is the capture edge
  assign captureNow = (state == TRACK) && anodeOk && same &&
                      (cnt == CW'(STABLE_CYCLES));
  assign raiseEv    = captureNow && legal && ((newVal != oldVal) || !oldValid);
  assign glyphBad   = captureNow && !legal && !blank;
  assign evBlocked  = EvValid && !EvReady;

  // Stability tracker: counter holds the number of identical samples seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (anodeOk) begin
            state <= TRACK;
            cnt   <= CW'(1);
          end else begin
            cnt <= '0;
          end
        end
        TRACK: begin
          if (!anodeOk) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (!same) begin
            cnt <= CW'(1);
          end else if (cnt == CW'(STABLE_CYCLES)) begin
            state <= LOCKED;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LOCKED: begin
          if (!anodeOk) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (!same) begin
            state <= TRACK;
            cnt   <= CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // ---- capture stage: shadow update, event port and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DigitsOut   <= '0;
      DigitValid  <= '0;
      EvValid     <= 1'b0;
      EvIdx       <= '0;
      EvData      <= '0;
      ErrGlyph    <= 1'b0;
      ErrOverflow <= 1'b0;
    end else begin
      if (captureNow && legal) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (i == int'(digitIdx)) begin
            DigitsOut[5*i +: 5] <= newVal;
            DigitValid[i]       <= 1'b1;
          end
        end
      end
      // A new event may overwrite the slot only when it is empty or being taken
      if (raiseEv && !evBlocked) begin
        EvValid <= 1'b1;
        EvIdx   <= digitIdx;
        EvData  <= newVal;
      end else if (EvValid && EvReady) begin
        EvValid <= 1'b0;
      end
      if (raiseEv && evBlocked) ErrOverflow <= 1'b1;
      else if (ErrClr)          ErrOverflow <= 1'b0;
      if (glyphBad)             ErrGlyph <= 1'b1;
      else if (ErrClr)          ErrGlyph <= 1'b0;
    end
  end

endmodule
